// File: rtl/demux_pkg.sv
// Shared types and helpers for the 1:2 buffered steering block.
package demux_pkg;

  typedef logic sel_t;

  localparam sel_t CH0 = 1'b0;
  localparam sel_t CH1 = 1'b1;

  // Occupancy needs to represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/chan_fifo.sv
// Per-channel synchronous FIFO with an explicit occupancy count.
module chan_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic                      pop,
  input  logic [WIDTH-1:0]          din,
  output logic [WIDTH-1:0]          head,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/demux2_buf.sv
// 1:2 steering block: each input word goes to the FIFO chosen by in_sel.
module demux2_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic                      in_sel,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      in_ready,
  output logic                      out0_valid,
  input  logic                      out0_ready,
  output logic [WIDTH-1:0]          out0_data,
  output logic                      out1_valid,
  input  logic                      out1_ready,
  output logic [WIDTH-1:0]          out1_data,
  output logic [cnt_w(DEPTH)-1:0]   count0,
  output logic [cnt_w(DEPTH)-1:0]   count1
);

  logic full0;
  logic full1;
  logic empty0;
  logic empty1;
  logic push0;
  logic push1;

  // Ready looks only at the selected channel's full flag, never at the
  // consumer's ready, so a pop cannot make room in the same cycle.
  assign in_ready = (in_sel == CH1) ? !full1 : !full0;
  assign push0    = in_valid && in_ready && (in_sel == CH0);
  assign push1    = in_valid && in_ready && (in_sel == CH1);

  assign out0_valid = !empty0;
  assign out1_valid = !empty1;

  chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo0 (
    .clk   (clk),
    .reset (reset),
    .push  (push0),
    .pop   (out0_ready),
    .din   (in_data),
    .head  (out0_data),
    .full  (full0),
    .empty (empty0),
    .count (count0)
  );

  chan_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .pop   (out1_ready),
    .din   (in_data),
    .head  (out1_data),
    .full  (full1),
    .empty (empty1),
    .count (count1)
  );

endmodule
